serial_port_sequencer: RTL and testbench
========================================

# serial_port_sequencer

Sequences the byte-level handshake between the Nios-side PIO ports (8-bit data out/in, transmit enable, character sent, character received, load) and the bit-level UART transmit and receive shifters. It turns the processor's level-driven transmit enable into a single-cycle start for the transmit shifter and reports completion. It also buffers received bytes in a small FIFO, presenting the oldest byte until the processor acknowledges it with load.

## Interface
- RX_DEPTH, 4, receive FIFO depth in bytes; power of two, ≥2.
- TX_TIMEOUT, 4096, maximum cycles to wait for tx_busy to rise after tx_start; 16-bit counter.

- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- cpu_data_out  in  8  byte to transmit (processor data bus out)
- cpu_transmit_enable  in  1  transmit request level from processor
- cpu_load  in  1  receive acknowledge from processor; rising edge pops one byte
- cpu_data_in  out  8  oldest received byte (processor data bus in)
- cpu_character_sent  out  1  transmit complete, held until request drops
- cpu_character_received  out  1  FIFO non-empty
- tx_data  out  8  byte to transmit shifter
- tx_start  out  1  one-cycle load strobe to transmit shifter
- tx_busy  in  1  transmit shifter active
- rx_data  in  8  byte from receive shifter
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_overrun  out  1  sticky: received byte dropped
- tx_fault  out  1  sticky: TX_TIMEOUT expired

## Operation
- Edge detectors: te_q and load_q register cpu_transmit_enable and cpu_load. Both reset to 1, so a level held high through reset is not a request.
- TX FSM states: T_IDLE, T_START, T_WAIT_BUSY, T_SHIFT, T_DONE.
  - T_IDLE: on te & !te_q, latch cpu_data_out into tx_data, go to T_START.
  - T_START: tx_start=1 for this cycle only, clear timeout counter, go to T_WAIT_BUSY.
  - T_WAIT_BUSY: if tx_busy, go to T_SHIFT. Otherwise increment counter; when it reaches TX_TIMEOUT-1, set tx_fault and go to T_DONE.
  - T_SHIFT: when tx_busy=0, go to T_DONE.
  - T_DONE: cpu_character_sent=1. When cpu_transmit_enable=0, go to T_IDLE.
- tx_data changes only on the T_IDLE→T_START transition.
- Four-phase handshake: the processor drops enable only after it sees character_sent. A new rising edge outside T_IDLE is ignored.
- RX FIFO: push on rx_valid, pop on load & !load_q.
  - Pop when empty is ignored.
  - Push when full without a simultaneous pop drops the byte and sets rx_overrun.
  - Push and pop in the same cycle when full: both take effect, count unchanged, no overrun.
  - Push and pop in the same cycle when empty: the byte is stored, the pop is ignored.
- Pointers are log2(RX_DEPTH) bits and wrap modulo RX_DEPTH. The count is log2(RX_DEPTH)+1 bits.
- cpu_data_in = FIFO head when non-empty, 8'h00 when empty. cpu_character_received = count≠0.
- rx_overrun and tx_fault clear only on reset.

## Timing
- Reset values:
  - tx FSM = T_IDLE.
  - tx_data = 0, tx_start = 0, cpu_character_sent = 0.
  - FIFO empty, cpu_data_in = 0, cpu_character_received = 0.
  - rx_overrun = 0, tx_fault = 0.
- Reset mid-operation aborts any transfer and flushes the FIFO. The shifter sees tx_start=0.
- Enable rising at cycle N: tx_start high in cycle N+1 (FSM is in T_START).
- tx_busy falling at cycle M: cpu_character_sent high from M+1.
- rx_valid at cycle N: cpu_character_received and cpu_data_in updated at N+1.
- Load rising edge sampled at N: head advances at N+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SPS_RX_FIFO_EN defined: RX buffering is the RX_DEPTH FIFO described above.
- SPS_RX_FIFO_EN undefined:
  - RX_DEPTH is ignored; a single 8-bit holding register plus a full flag replaces the FIFO.
  - Overrun, simultaneous push/pop, and empty-read rules are identical with depth 1.

## Test plan
- Transmit: cpu_data_out=8'hA5, enable rises; tx_busy rises 3 cycles after tx_start and falls 80 cycles later. Required: exactly one tx_start pulse, tx_data=8'hA5, character_sent high until enable drops, then low one cycle later.
- Timeout: tx_busy held 0 after start with TX_TIMEOUT=16. Required: tx_fault=1 and character_sent=1 exactly 16 cycles after T_WAIT_BUSY entry.
- FIFO order: push 8'h11, 8'h22, 8'h33, then three load pulses. Required: cpu_data_in reads 11, 22, 33, then 00; character_received falls after the third pop.
- Overrun: push 5 bytes with RX_DEPTH=4. Required: 5th byte dropped, rx_overrun=1, first four bytes intact; then a push and pop in the same cycle while full gives no further loss and count stays 4.
- Reset: assert reset mid-shift with 2 bytes buffered. Required: all outputs at reset values; enable held high across deassertion produces no tx_start.
- Build without SPS_RX_FIFO_EN: push 8'h5A, 8'h6B. Required: 8'h5A held, rx_overrun=1.

Source files
------------

// File: rtl/serial_port_sequencer.sv
// serial_port_sequencer: PIO-to-UART byte handshake; RX buffering selected by SPS_RX_FIFO_EN (FIFO) or a single holding register
module serial_port_sequencer #(
    parameter int RX_DEPTH   = 4,
    parameter int TX_TIMEOUT = 4096
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [7:0] cpu_data_out,
    input  logic       cpu_transmit_enable,
    input  logic       cpu_load,
    output logic [7:0] cpu_data_in,
    output logic       cpu_character_sent,
    output logic       cpu_character_received,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_overrun,
    output logic       tx_fault
);
    typedef enum logic [2:0] {T_IDLE, T_START, T_WAIT_BUSY, T_SHIFT, T_DONE} tx_state_t;
    tx_state_t   state;
    logic [15:0] tmo_cnt;
    logic        te_q;
    logic        load_q;
    logic        pop_req;
    assign pop_req = cpu_load & ~load_q;
    // previous levels of the processor strobes; reset high so a level held through reset is not an edge
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            te_q   <= 1'b1;
            load_q <= 1'b1;
        end else begin
            te_q   <= cpu_transmit_enable;
            load_q <= cpu_load;
        end
    end
    // transmit sequencer: enable edge -> one start strobe -> wait for shifter -> report done
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state              <= T_IDLE;
            tx_data            <= 8'h00;
            tx_start           <= 1'b0;
            cpu_character_sent <= 1'b0;
            tx_fault           <= 1'b0;
            tmo_cnt            <= 16'd0;
        end else begin
            case (state)
                T_IDLE: if (cpu_transmit_enable && !te_q) begin
                    tx_data  <= cpu_data_out;
                    tx_start <= 1'b1;
                    state    <= T_START;
                end
                T_START: begin
                    tx_start <= 1'b0;
                    tmo_cnt  <= 16'd0;
                    state    <= T_WAIT_BUSY;
                end
                T_WAIT_BUSY: if (tx_busy) begin
                    state <= T_SHIFT;
                end else if (tmo_cnt == 16'(TX_TIMEOUT - 1)) begin
                    tx_fault           <= 1'b1;
                    cpu_character_sent <= 1'b1;
                    state              <= T_DONE;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
                T_SHIFT: if (!tx_busy) begin
                    cpu_character_sent <= 1'b1;
                    state              <= T_DONE;
                end
                T_DONE: if (!cpu_transmit_enable) begin
                    cpu_character_sent <= 1'b0;
                    state              <= T_IDLE;
                end
                default: state <= T_IDLE;
            endcase
        end
    end
`ifdef SPS_RX_FIFO_EN
    localparam int AW = $clog2(RX_DEPTH);
    logic [7:0]  mem [RX_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [AW:0]   count, cnt_nxt;
    logic          full, do_pop, do_push;
    assign full    = count == (AW+1)'(RX_DEPTH);
    assign do_pop  = pop_req && count != '0;
    assign do_push = rx_valid && (!full || do_pop);
    assign rd_nxt  = rd_ptr + AW'(do_pop);
    assign cnt_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // byte storage needs no reset; validity is tracked by count
    always_ff @(posedge clk_clk) begin
        if (do_push) mem[wr_ptr] <= rx_data;
    end
    // pointers, occupancy and the registered head presented to the processor
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rd_ptr                 <= '0;
            wr_ptr                 <= '0;
            count                  <= '0;
            rx_overrun             <= 1'b0;
            cpu_data_in            <= 8'h00;
            cpu_character_received <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            if (rx_valid && !do_push) rx_overrun <= 1'b1;
            cpu_character_received <= cnt_nxt != '0;
            cpu_data_in <= cnt_nxt == '0 ? 8'h00 : (do_push && rd_nxt == wr_ptr) ? rx_data : mem[rd_nxt];
        end
    end
`else
    logic unused_depth;
    logic do_pop, accept;
    assign unused_depth = ^RX_DEPTH;
    assign do_pop = pop_req && cpu_character_received;
    assign accept = rx_valid && (!cpu_character_received || do_pop);
    // single holding register; cpu_character_received doubles as its full flag
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cpu_data_in            <= 8'h00;
            cpu_character_received <= 1'b0;
            rx_overrun             <= 1'b0;
        end else begin
            cpu_data_in            <= accept ? rx_data : do_pop ? 8'h00 : cpu_data_in;
            cpu_character_received <= accept || (cpu_character_received && !do_pop);
            if (rx_valid && !accept) rx_overrun <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_serial_port_sequencer.sv
// tb_serial_port_sequencer: randomized bench against a queue/arithmetic model of the sequencer
module tb_serial_port_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
`ifdef SPS_RX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] cpu_data_out = 8'h00;
    logic cpu_transmit_enable = 1'b0;
    logic cpu_load = 1'b0;
    logic [7:0] cpu_data_in;
    logic cpu_character_sent, cpu_character_received;
    logic [7:0] tx_data;
    logic tx_start;
    logic tx_busy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic rx_overrun, tx_fault;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q [$];
    bit ovr_m = 1'b0;
    bit fault_m = 1'b0;
    logic ld_prev = 1'b1;

    serial_port_sequencer #(.RX_DEPTH(DEPTH), .TX_TIMEOUT(TMO)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .cpu_data_out(cpu_data_out), .cpu_transmit_enable(cpu_transmit_enable), .cpu_load(cpu_load),
        .cpu_data_in(cpu_data_in), .cpu_character_sent(cpu_character_sent),
        .cpu_character_received(cpu_character_received),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun), .tx_fault(tx_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_sent", cpu_character_sent, 0);
        check("rst_data_in", cpu_data_in, 0);
        check("rst_rcvd", cpu_character_received, 0);
        check("rst_overrun", rx_overrun, 0);
        check("rst_fault", tx_fault, 0);
    endtask

    // one receive-side cycle: drive, clock, advance the queue model, compare
    task automatic rx_step(input logic v, input logic [7:0] d, input logic ld);
        rx_valid = v;
        rx_data  = d;
        cpu_load = ld;
        @(posedge clk);
        if (ld && !ld_prev && q.size() > 0) void'(q.pop_front());
        if (v) begin
            if (q.size() < CAP) q.push_back(d);
            else ovr_m = 1'b1;
        end
        ld_prev = ld;
        #1;
        check("data_in", cpu_data_in, q.size() > 0 ? {24'd0, q[0]} : 32'd0);
        check("char_rcvd", cpu_character_received, q.size() > 0);
        check("overrun", rx_overrun, ovr_m);
        check("tx_start_idle", tx_start, 0);
        rx_valid = 1'b0;
    endtask

    // one transmit: busy rises dly cycles after tx_start and stays len cycles, or never rises when tmo
    task automatic tx_xfer(input logic [7:0] d, input int dly, input int len, input bit tmo);
        int pulses;
        int done_at;
        done_at = tmo ? TMO + 1 : dly + len + 1;
        cpu_data_out = d;
        cpu_transmit_enable = 1'b1;
        @(posedge clk);
        #1;
        pulses = int'(tx_start);
        check("tx_start", tx_start, 1);
        check("tx_data", tx_data, d);
        cpu_data_out = ~d;
        for (int c = 1; c <= done_at + 3; c++) begin
            @(posedge clk);
            #1;
            tx_busy = !tmo && c >= dly && c < dly + len;
            pulses += int'(tx_start);
            check("sent", cpu_character_sent, c >= done_at);
            check("fault", tx_fault, fault_m || (tmo && c >= done_at));
            check("tx_data_hold", tx_data, d);
        end
        check("tx_pulses", pulses, 1);
        if (tmo) fault_m = 1'b1;
        cpu_transmit_enable = 1'b0;
        @(posedge clk);
        #1;
        check("sent_drop", cpu_character_sent, 0);
        ld_prev = cpu_load;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ld_prev = 1'b0;
        tx_xfer(8'hA5, 3, 80, 1'b0);
        for (int i = 0; i < 6; i++)
            tx_xfer(8'($urandom), $urandom_range(1, 8), $urandom_range(1, 30), 1'b0);
        rx_step(1'b1, 8'h11, 1'b0);
        rx_step(1'b1, 8'h22, 1'b0);
        rx_step(1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rx_step(1'b0, 8'h00, 1'b1);
            rx_step(1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 200; i++)
            rx_step($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i <= CAP; i++) begin
            rx_step(1'b0, 8'h00, 1'b0);
            rx_step(1'b0, 8'h00, 1'b1);
        end
        rx_step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) rx_step(1'b1, 8'($urandom), 1'b0);
        rx_step(1'b1, 8'($urandom), 1'b1);
        for (int i = 0; i <= CAP; i++) begin
            rx_step(1'b0, 8'h00, 1'b0);
            rx_step(1'b0, 8'h00, 1'b1);
        end
        tx_xfer(8'h5C, 0, 0, 1'b1);
        rx_step(1'b1, 8'h77, 1'b0);
        rx_step(1'b1, 8'h88, 1'b0);
        cpu_data_out = 8'h3C;
        cpu_transmit_enable = 1'b1;
        @(posedge clk);
        #1;
        tx_busy = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset();
        tx_busy = 1'b0;
        q.delete();
        ovr_m = 1'b0;
        fault_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("no_start_after_rst", tx_start, 0);
            check("no_sent_after_rst", cpu_character_sent, 0);
        end
        ld_prev = cpu_load;
        cpu_transmit_enable = 1'b0;
        @(posedge clk);
        #1;
        tx_xfer(8'($urandom), 2, 10, 1'b0);
        rx_step(1'b1, 8'h5A, 1'b0);
        rx_step(1'b1, 8'h6B, 1'b0);
        rx_step(1'b0, 8'h00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
